// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage state encoding, IF/ID entry type and the reset PC
package pipeline_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC = 32'h6000_0000;
  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, DISCARD = 2'd2} fetch_state_t;
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/pipeline_fetch_stage_if.sv
// pipeline_fetch_stage_if: imem request/response bus plus IF/ID valid/ready head; master = fetch stage
interface pipeline_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] imem_addr;
  logic [3:0]      imem_rmask;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_resp;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            id_ready;
  modport master (
    output imem_addr, imem_rmask, if_valid, if_pc, if_instr,
    input  imem_rdata, imem_resp, id_ready
  );
  modport slave (
    input  imem_addr, imem_rmask, if_valid, if_pc, if_instr,
    output imem_rdata, imem_resp, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of {pc,instr}; enq_i/deq_i/flush_i in, count_o/head_o/valid_o out, flush wins
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_i,
  input  fetch_entry_t           data_i,
  input  logic                   deq_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o,
  output logic                   valid_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q <= wr_q;
      count_q <= '0;
    end else begin
      if (enq_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (deq_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + (AW + 1)'(enq_i) - (AW + 1)'(deq_i);
    end
  end
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
  assign valid_o = count_q != '0;
endmodule

// File: rtl/pipeline_fetch_stage.sv
// pipeline_fetch_stage: one-outstanding imem fetch FSM with credit, stall and mispredict squash into the IF/ID FIFO
module pipeline_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = WORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         pc,
  input  logic                    mispredict_br_en,
  output logic                    fetch_stall,
  pipeline_fetch_stage_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  fetch_state_t state_q, state_d;
  logic [CW-1:0] count;
  fetch_entry_t head;
  logic issue, accept, deq;
  assign issue  = !rst && state_q == REQ && count < FULL && !mispredict_br_en;
  assign accept = state_q == WAIT && bus.imem_resp && !mispredict_br_en;
  assign deq    = bus.if_valid && bus.id_ready;
  assign bus.imem_addr  = {pc[XLEN-1:2], 2'b00};
  assign bus.imem_rmask = issue ? 4'hF : 4'h0;
  assign fetch_stall    = !accept;
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     state_d = issue ? WAIT : REQ;
      WAIT:    state_d = bus.imem_resp ? REQ : (mispredict_br_en ? DISCARD : WAIT);
      DISCARD: state_d = bus.imem_resp ? REQ : DISCARD;
      default: state_d = REQ;
    endcase
  end
  always_ff @(posedge clk) state_q <= rst ? REQ : state_d;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .enq_i   (accept),
    .data_i  ('{pc: pc, instr: bus.imem_rdata}),
    .deq_i   (deq),
    .flush_i (mispredict_br_en),
    .count_o (count),
    .head_o  (head),
    .valid_o (bus.if_valid)
  );
  assign bus.if_pc    = head.pc;
  assign bus.if_instr = head.instr;
endmodule
